// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational freeze/flush controls,
// a memory-wait watchdog FSM and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             cnt_clr,
   output logic             freeze_if,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             freeze_back,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned    WW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // wait_cnt_q holds the number of stalled cycles already completed
   localparam logic [WW-1:0]  LAST_WAIT = WW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

   state_e           state_q;
   logic [WW-1:0]    wait_cnt_q;
   logic             mem_fault_q;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   logic mem_stall;
   logic in_fault;
   logic fb_raw;
   logic fi_raw;
   logic fif_raw;
   logic fie_raw;

   always_comb begin
      in_fault  = (state_q == StFault);
      mem_stall = ~in_fault & mem_req & ~mem_ready;
      fb_raw    = mem_stall | in_fault;
      // A taken branch squashes the hazarding instruction, so it cancels the IF freeze
      fi_raw    = fb_raw | (hazard & ~branch_taken);
      // Stage registers give flush priority over freeze, so flushes must be masked here
      fif_raw   = branch_taken & ~fb_raw;
      fie_raw   = (branch_taken | hazard) & ~fb_raw;

      freeze_back  = fb_raw & ~rst;
      freeze_if    = fi_raw & ~rst;
      flush_if_id  = fif_raw & ~rst;
      flush_id_ex  = fie_raw & ~rst;
      mem_fault    = mem_fault_q;
      stall_cycles = stall_q;
      flush_cnt    = flush_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         mem_fault_q <= 1'b0;
         stall_q     <= '0;
         flush_q     <= '0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mem_stall) begin
                  if (TIMEOUT == 1) begin
                     state_q <= StFault;
                  end else begin
                     state_q    <= StMemWait;
                     wait_cnt_q <= WW'(1);
                  end
               end
            end
            StMemWait: begin
               if (!mem_stall) begin
                  state_q    <= StRun;
                  wait_cnt_q <= '0;
               end else if (TIMEOUT != 0 && wait_cnt_q == LAST_WAIT) begin
                  state_q <= StFault;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WW'(1);
               end
            end
            StFault: begin
               mem_fault_q <= 1'b1;
            end
            default: begin
               state_q <= StRun;
            end
         endcase

         if (cnt_clr) begin
            stall_q <= '0;
         end else if (fi_raw && stall_q != CNT_MAX) begin
            stall_q <= stall_q + CNT_W'(1);
         end

         if (cnt_clr) begin
            flush_q <= '0;
         end else if (fif_raw && flush_q != CNT_MAX) begin
            flush_q <= flush_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage ARM pipeline. It generates the freeze and flush controls for the PC/IF_ID, ID_EX and back-end (EX_MEM, MEM_WB) stage registers from the load-use hazard, the EX-stage branch decision and the MEM-stage SRAM handshake. It runs a memory-wait watchdog and keeps saturating stall/flush performance counters. It sits beside the hazard-detection unit and drives every stage register's freeze/flush pins.

## Interface
- TIMEOUT, 16: maximum consecutive memory-stall cycles before fault; 0 disables the watchdog.
- CNT_W, 16: width of the performance counters.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- hazard  in  1  load-use hazard from the hazard-detection unit (ID stage).
- branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage holds a load/store (level).
- mem_ready  in  1  SRAM access complete this cycle.
- cnt_clr  in  1  synchronous clear of both performance counters.
- freeze_if  out  1  hold PC register and IF_ID.
- flush_if_id  out  1  squash IF_ID.
- flush_id_ex  out  1  insert a bubble into ID_EX.
- freeze_back  out  1  hold ID_EX, EX_MEM and MEM_WB.
- mem_fault  out  1  watchdog fired; sticky until rst.
- stall_cycles  out  CNT_W  cycles with freeze_if=1, saturating.
- flush_cnt  out  CNT_W  cycles with flush_if_id=1, saturating.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- mem_stall = mem_req & ~mem_ready, evaluated in RUN or MEM_WAIT.
- freeze_back = mem_stall | (state==FAULT).
- freeze_if = freeze_back | (hazard & ~branch_taken).
- flush_if_id = branch_taken & ~freeze_back.
- flush_id_ex = (branch_taken | hazard) & ~freeze_back.
- Flushes must be masked while freeze_back=1. The stage registers give flush priority over freeze, so an unmasked flush would destroy frozen state. During a memory stall the EX stage is held, so branch_taken persists and is applied on release.
- branch_taken and hazard together: branch wins. Both flushes are asserted and freeze_if=0, because the hazarding instruction is squashed.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_stall. wait_cnt is set to 1 (the first stalled cycle counts as 1).
  - MEM_WAIT -> RUN when mem_ready=1 or mem_req=0. That cycle is unstalled, combinationally.
  - MEM_WAIT, still stalled: wait_cnt increments.
  - MEM_WAIT -> FAULT when TIMEOUT≠0 and the stalled cycle with wait_cnt==TIMEOUT still has mem_ready=0.
  - FAULT: all freezes held, all flushes 0, mem_fault=1. Exit only via rst.
- wait_cnt is 0 in RUN, with width sized for TIMEOUT.
- Counters: increment on the stated condition and saturate at 2^CNT_W-1.
  - cnt_clr beats increment: the count is 0 next cycle, even if the condition holds.
  - In FAULT, stall_cycles keeps counting.

## Timing
- All freeze/flush outputs are combinational from the current state and inputs. There is zero-cycle latency to the stage registers.
- State, wait_cnt, mem_fault and the counters are registered; their updates are visible the cycle after the event.
- Reset values: state RUN, wait_cnt 0, mem_fault 0, stall_cycles 0, flush_cnt 0.
  - With inputs idle, all freeze/flush outputs are 0.
  - While rst=1, all freeze/flush outputs are forced 0.
- Reset asserted mid-stall or in FAULT: RUN and all registers cleared on that edge.
- mem_req and mem_ready high in the same cycle: no stall, and the FSM stays in RUN.

## Test plan
- Load-use: hazard=1 for 1 cycle, no branch -> freeze_if=1 and flush_id_ex=1 for that cycle, flush_if_id=0, stall_cycles=1 the next cycle.
- Branch + hazard same cycle -> flush_if_id=1, flush_id_ex=1, freeze_if=0, flush_cnt increments by 1.
- Memory wait:
  - Stimulus: mem_req=1 with mem_ready low for 3 cycles, then high.
  - Response: freeze_back=1 for exactly 3 cycles; state goes RUN -> MEM_WAIT -> RUN; stall_cycles=3.
- Branch during memory stall: branch_taken=1 throughout a 2-cycle stall -> flush_if_id=0 during the stall and 1 on the release cycle.
- Watchdog with TIMEOUT=4 and mem_ready held 0:
  - Stalled cycles 1–4, then FAULT; mem_fault=1 from cycle 6 onward.
  - Freezes stay high and nothing changes until rst; after rst everything returns to the reset values.
- Counter saturation with CNT_W=4:
  - 20 hazard cycles -> stall_cycles=15.
  - cnt_clr asserted together with hazard -> stall_cycles=0 the next cycle.
